glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_sequencer_pkg.sv | 22 ++
 rtl/glitch_sequencer_sync_edge.sv | 41 ++++
 rtl/glitch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_glitch_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_sequencer_pkg.sv
// Shared types and constants for the glitch sequencer.
// Holds the controller state encoding and the default counter width.
package glitch_sequencer_pkg;

   localparam int DELAY_W_DEF     = 32;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_FIRE  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Busy covers the whole trigger-to-completion window.
   function automatic logic is_busy(input state_e s);
      return (s == ST_DELAY) || (s == ST_FIRE) || (s == ST_WAIT);
   endfunction

endpackage

// File: rtl/glitch_sequencer_sync_edge.sv
// Synchronizer for the asynchronous target trigger followed by a
// registered rising-edge detector; edge_o is a one-cycle pulse.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic edge_o
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;
   logic              edge_q;
   logic              edge_d;

   // Shift the raw trigger into the chain and detect a 0->1 transition at its end.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_i};
      edge_d = sync_q[STAGES-1] & ~prev_q;
   end

   // Synchronizer and edge-detector registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[STAGES-1];
         edge_q <= edge_d;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-to-fire glitch sequencer: arms with captured settings, waits a
// programmable number of cycles after a trigger edge, then starts the pattern stage.
module glitch_sequencer
   import glitch_sequencer_pkg::*;
#(
   parameter int DELAY_W     = DELAY_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               disarm,
   input  logic               trigger_in,
   input  logic [DELAY_W-1:0] delay,
   input  logic [7:0]         pattern_in,
   input  logic [7:0]         pattern_cnt_in,
   input  logic               pat_rdy,
   output logic               pat_en,
   output logic [7:0]         pat_pattern,
   output logic [7:0]         pat_pattern_cnt,
   output logic               armed,
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   localparam logic [DELAY_W-1:0] CNT_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [7:0]         pattern_q, pattern_d;
   logic [7:0]         pattern_cnt_q, pattern_cnt_d;
   logic               overrun_q, overrun_d;
   logic               pat_en_q, pat_en_d;
   logic               armed_q, armed_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wait_first_q, wait_first_d;
   logic               trig_edge_s;

   sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .async_i(trigger_in),
      .edge_o (trig_edge_s)
   );

   // Next-state and next-output logic for the sequencing FSM.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      delay_d       = delay_q;
      pattern_d     = pattern_q;
      pattern_cnt_d = pattern_cnt_q;
      overrun_d     = overrun_q;
      pat_en_d      = 1'b0;
      wait_first_d  = (state_q == ST_FIRE);

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               delay_d       = delay;
               pattern_d     = pattern_in;
               pattern_cnt_d = pattern_cnt_in;
               overrun_d     = 1'b0;
               state_d       = ST_ARMED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (disarm) begin
               state_d = ST_IDLE;
            end else if (trig_edge_s) begin
               cnt_d = delay_q;
               if (delay_q == '0) begin
                  state_d = ST_FIRE;
               end else begin
                  state_d = ST_DELAY;
               end
            end else begin
               state_d = ST_ARMED;
            end
         end
         // Counter is loaded with delay, so reaching 1 leaves exactly one FIRE cycle.
         ST_DELAY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (disarm) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_ONE) begin
               state_d = ST_FIRE;
            end else begin
               state_d = ST_DELAY;
            end
         end
         ST_FIRE: begin
            if (pat_rdy) begin
               pat_en_d = 1'b1;
               state_d  = ST_WAIT;
            end else begin
               overrun_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         // pat_rdy is still stale on the first cycle after the start strobe.
         ST_WAIT: begin
            if (!wait_first_q && pat_rdy) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      armed_d = (state_d == ST_ARMED);
      busy_d  = is_busy(state_d);
      done_d  = (state_d == ST_DONE);
   end

   // State, captured settings and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         delay_q       <= '0;
         pattern_q     <= 8'h00;
         pattern_cnt_q <= 8'h00;
         overrun_q     <= 1'b0;
         pat_en_q      <= 1'b0;
         armed_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         wait_first_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         delay_q       <= delay_d;
         pattern_q     <= pattern_d;
         pattern_cnt_q <= pattern_cnt_d;
         overrun_q     <= overrun_d;
         pat_en_q      <= pat_en_d;
         armed_q       <= armed_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         wait_first_q  <= wait_first_d;
      end
   end

   assign pat_en          = pat_en_q;
   assign pat_pattern     = pattern_q;
   assign pat_pattern_cnt = pattern_cnt_q;
   assign armed           = armed_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a timestamp-based model predicts every
// output each cycle, and literal expectations pin the fire latency and flags.
module tb_glitch_sequencer;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst, arm, disarm, trigger_in, pat_rdy;
   logic [31:0] delay;
   logic [7:0]  pattern_in, pattern_cnt_in;
   logic        pat_en, armed, busy, done, overrun;
   logic [7:0]  pat_pattern, pat_pattern_cnt;

   int errors = 0;
   int checks = 0;

   glitch_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .arm            (arm),
      .disarm         (disarm),
      .trigger_in     (trigger_in),
      .delay          (delay),
      .pattern_in     (pattern_in),
      .pattern_cnt_in (pattern_cnt_in),
      .pat_rdy        (pat_rdy),
      .pat_en         (pat_en),
      .pat_pattern    (pat_pattern),
      .pat_pattern_cnt(pat_pattern_cnt),
      .armed          (armed),
      .busy           (busy),
      .done           (done),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_ARMED, M_RUN, M_WAIT, M_DONE} mmode_e;
   mmode_e          mode = M_IDLE;
   longint          cyc = 0;
   longint unsigned fire_at, wait_from, cap_delay;
   bit              hv [0:15];
   bit              edge_seen, chk_en = 1'b0;
   bit              e_pat_en, e_armed, e_busy, e_done, e_overrun;
   bit [7:0]        e_pat, e_cnt;

   always @(posedge clk) begin
      cyc++;
      // The controller sees a rise S+1 edges after the raw level is first sampled high.
      edge_seen = hv[S] && !hv[S+1];
      for (int k = 15; k > 0; k--) hv[k] = hv[k-1];
      hv[0] = trigger_in;
      if (rst) begin
         for (int k = 0; k < 16; k++) hv[k] = 1'b0;
         mode = M_IDLE; chk_en = 1'b1;
         e_pat_en = 0; e_armed = 0; e_busy = 0; e_done = 0; e_overrun = 0;
         e_pat = 8'h00; e_cnt = 8'h00;
      end else begin
         e_pat_en = 0; e_done = 0;
         case (mode)
            M_IDLE: if (arm) begin
               cap_delay = 64'(delay); e_pat = pattern_in; e_cnt = pattern_cnt_in;
               e_overrun = 0; mode = M_ARMED;
            end
            M_ARMED: if (disarm) mode = M_IDLE;
                     else if (edge_seen) begin fire_at = cyc + cap_delay + 1; mode = M_RUN; end
            M_RUN: if (cyc < fire_at) begin
                      if (disarm) mode = M_IDLE;
                   end else if (pat_rdy) begin
                      e_pat_en = 1; wait_from = cyc; mode = M_WAIT;
                   end else begin
                      e_overrun = 1; e_done = 1; mode = M_DONE;
                   end
            M_WAIT: if (cyc >= wait_from + 2 && pat_rdy) begin e_done = 1; mode = M_DONE; end
            M_DONE: mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
         e_armed = (mode == M_ARMED);
         e_busy  = (mode == M_RUN) || (mode == M_WAIT);
      end
   end

   // ---------------- per-cycle compare and event monitor ----------------
   int     pe_cnt = 0, done_cnt = 0;
   longint pe_cyc = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("pat_en", pat_en, e_pat_en);
         check("armed", armed, e_armed);
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("overrun", overrun, e_overrun);
         check("pat_pattern", pat_pattern, e_pat);
         check("pat_pattern_cnt", pat_pattern_cnt, e_cnt);
      end
      if (pat_en === 1'b1) begin pe_cnt++; pe_cyc = cyc; end
      if (done === 1'b1) done_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_arm(input logic [31:0] d, input logic [7:0] p, input logic [7:0] c);
      delay = d; pattern_in = p; pattern_cnt_in = c; arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic pulse_disarm();
      disarm = 1'b1; step(); disarm = 1'b0;
   endtask

   task automatic wait_pe(input int budget, input int base);
      int n = budget;
      while (pe_cnt == base && n > 0) begin step(); n--; end
      check("pat_en_seen", 64'(pe_cnt - base), 64'd1);
   endtask

   task automatic wait_done(input int budget, input int base);
      int n = budget;
      while (done_cnt == base && n > 0) begin step(); n--; end
      check("done_seen", 64'(done_cnt - base), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint c;
      int     pb, db;
      rst = 1'b1; arm = 1'b0; disarm = 1'b0; trigger_in = 1'b0; pat_rdy = 1'b1;
      delay = 32'd0; pattern_in = 8'h00; pattern_cnt_in = 8'h00;
      step(3);
      check("rst_armed", armed, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_pattern", pat_pattern, 8'h00);
      rst = 1'b0;
      step(2);

      // delay=5: fire 10 edges after trigger goes high (3 sync/edge + 1 sample + 6)
      pb = pe_cnt; db = done_cnt;
      do_arm(32'd5, 8'h55, 8'd0);
      check("s1_armed", armed, 1'b1);
      trigger_in = 1'b1; c = cyc;
      wait_pe(40, pb);
      check("s1_fire_offset", 64'(pe_cyc - c), 64'd10);
      check("s1_pattern", pat_pattern, 8'h55);
      pat_rdy = 1'b0; step(3); pat_rdy = 1'b1;
      wait_done(20, db);
      step(3);
      check("s1_done_once", 64'(done_cnt - db), 64'd1);
      trigger_in = 1'b0; step(5);

      // delay=0
      pb = pe_cnt; db = done_cnt;
      do_arm(32'd0, 8'h0F, 8'd3);
      trigger_in = 1'b1; c = cyc;
      wait_pe(20, pb);
      check("s2_fire_offset", 64'(pe_cyc - c), 64'd5);
      check("s2_pattern_cnt", pat_pattern_cnt, 8'd3);
      wait_done(20, db);
      trigger_in = 1'b0; step(5);

      // disarm mid-DELAY
      pb = pe_cnt; db = done_cnt;
      do_arm(32'd100, 8'h11, 8'd1);
      trigger_in = 1'b1; step(14);
      check("s3_busy_before", busy, 1'b1);
      pulse_disarm(); step(2);
      check("s3_armed", armed, 1'b0);
      check("s3_busy", busy, 1'b0);
      step(110);
      check("s3_no_fire", 64'(pe_cnt - pb), 64'd0);
      check("s3_no_done", 64'(done_cnt - db), 64'd0);
      trigger_in = 1'b0; step(5);

      // overrun with pat_rdy low, then re-arm clears it
      pb = pe_cnt; db = done_cnt;
      pat_rdy = 1'b0;
      do_arm(32'd3, 8'h12, 8'd2);
      trigger_in = 1'b1; step(15);
      check("s4_overrun", overrun, 1'b1);
      check("s4_no_fire", 64'(pe_cnt - pb), 64'd0);
      check("s4_done", 64'(done_cnt - db), 64'd1);
      trigger_in = 1'b0; step(4);
      do_arm(32'd7, 8'hAA, 8'd4);
      check("s4_overrun_clr", overrun, 1'b0);
      check("s4_pattern", pat_pattern, 8'hAA);
      pulse_disarm(); pat_rdy = 1'b1; step(2);

      // second edge in DELAY and arm in WAIT are ignored
      pb = pe_cnt; db = done_cnt;
      do_arm(32'd7, 8'h3C, 8'd5);
      trigger_in = 1'b1; c = cyc;
      step(3); trigger_in = 1'b0; step(2); trigger_in = 1'b1;
      wait_pe(40, pb);
      check("s5_fire_offset", 64'(pe_cyc - c), 64'd12);
      pat_rdy = 1'b0;
      do_arm(32'd9, 8'hC3, 8'd9);
      check("s5_pattern_kept", pat_pattern, 8'h3C);
      check("s5_cnt_kept", pat_pattern_cnt, 8'd5);
      step(2); pat_rdy = 1'b1;
      wait_done(20, db);
      trigger_in = 1'b0; step(5);

      // rst mid-DELAY
      pb = pe_cnt;
      do_arm(32'd20, 8'h77, 8'h66);
      trigger_in = 1'b1; step(10);
      rst = 1'b1; step(); rst = 1'b0;
      check("s6_busy", busy, 1'b0);
      check("s6_pattern", pat_pattern, 8'h00);
      check("s6_cnt", pat_pattern_cnt, 8'h00);
      step(40);
      check("s6_no_fire", 64'(pe_cnt - pb), 64'd0);
      trigger_in = 1'b0; step(5);

      // edge while IDLE is discarded
      pb = pe_cnt;
      trigger_in = 1'b1; step(8);
      do_arm(32'd2, 8'h5A, 8'd1);
      step(20);
      check("s7_no_fire", 64'(pe_cnt - pb), 64'd0);
      check("s7_still_armed", armed, 1'b1);
      pulse_disarm(); trigger_in = 1'b0; step(5);

      // all-ones delay keeps counting without wrap
      pb = pe_cnt;
      do_arm(32'hFFFF_FFFF, 8'hF0, 8'd0);
      trigger_in = 1'b1; step(30);
      check("s8_busy", busy, 1'b1);
      check("s8_no_fire", 64'(pe_cnt - pb), 64'd0);
      pulse_disarm(); step(2);
      check("s8_idle", busy, 1'b0);
      trigger_in = 1'b0; step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
